seq_multiplier: RTL and testbench

Parametrised sequential shift-add multiplier with an integrated control unit. It is the successor to the fixed 8-bit multiplier control unit. Operand width is a parameter, a busy/done handshake is added, back-to-back operation is supported, and signed mode can be compiled in. It sits beside the ALU datapath, which issues `start` with operands and collects `result` on `DONE`.

---
 rtl/seq_mult_pkg.sv | 25 ++
 rtl/seq_mult_dp.sv | 87 ++++++++
 rtl/seq_multiplier.sv | 129 ++++++++++++
 tb/tb_seq_multiplier.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
`timescale 1ns/1ps
// seq_mult_pkg: state type, state encodings and counter sizing shared by the multiplier files.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_mult_pkg;

  // State encodings, kept explicit so waveform values stay stable across builds.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    FIX  = ST_FIX,
    FIN  = ST_FIN
  } state_t;

  // Step counter width: must be able to hold WIDTH itself after the last increment.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mult_dp.sv
`timescale 1ns/1ps
// seq_mult_dp: M/Q/A registers, shift-add step, sign handling and result register.
// Latency: each enable takes effect on the next rising edge; result updates on commit.
// Backpressure: none; obeys the load/step/negate/commit enables from the control unit.
module seq_mult_dp
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic                 negate,
  input  logic                 commit,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  input  logic                 sgn,
  output logic [2*WIDTH-1:0]   result
);

  // M: multiplicand magnitude, Q: multiplier magnitude (low product half at the end),
  // A: accumulator with one guard bit that catches the carry of A+M.
  logic [WIDTH-1:0]   m_q;
  logic [WIDTH-1:0]   q_q;
  logic [WIDTH:0]     a_q;
  logic               neg_q;

  logic [WIDTH-1:0]   x_abs;
  logic [WIDTH-1:0]   y_abs;
  logic               neg_in;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;

  // Operand magnitudes, partial sum and the two's-complement of the finished product.
  always_comb begin
    x_abs  = x;
    y_abs  = y;
    neg_in = 1'b0;
    if (sgn) begin
      // Negating the most negative value yields 2^(WIDTH-1), which is the correct
      // unsigned magnitude, so no special case is needed.
      if (x[WIDTH-1]) x_abs = '0 - x;
      if (y[WIDTH-1]) y_abs = '0 - y;
      neg_in = x[WIDTH-1] ^ y[WIDTH-1];
    end
    // A always has a clear guard bit before the add, so A+M never overflows WIDTH+1 bits.
    sum      = q_q[0] ? (a_q + {1'b0, m_q}) : a_q;
    prod     = {a_q[WIDTH-1:0], q_q};
    prod_neg = '0 - prod;
  end

  // Operand capture, one shift-add step per cycle, and the optional final negate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q   <= '0;
      q_q   <= '0;
      a_q   <= '0;
      neg_q <= 1'b0;
    end else if (load) begin
      m_q   <= x_abs;
      q_q   <= y_abs;
      a_q   <= '0;
      neg_q <= neg_in;
    end else if (step) begin
      // Shift {sum, Q} right by one: sum's carry drops back into A, sum[0] enters Q.
      a_q <= {1'b0, sum[WIDTH:1]};
      q_q <= {sum[0], q_q[WIDTH-1:1]};
    end else if (negate && neg_q) begin
      // A zero product negates to zero, so a set sign flag on 0 is harmless.
      a_q <= {1'b0, prod_neg[2*WIDTH-1:WIDTH]};
      q_q <= prod_neg[WIDTH-1:0];
    end
  end

  // Result register: samples the finished product on commit and holds it otherwise.
  // A load on the same edge does not disturb it because commit reads the old A/Q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
    end else if (commit) begin
      result <= prod;
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
`timescale 1ns/1ps
// seq_multiplier: shift-add multiplier control unit; SEQ_MULT_SIGNED_EN adds sgn port and FIX state.
// Latency: DONE/result WIDTH+1 edges after the accepting edge (WIDTH+2 with SEQ_MULT_SIGNED_EN).
// Backpressure: start is taken only in IDLE or FIN; start while busy is dropped, not queued.
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 RESET,
  input  logic                 start,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic                 sgn,
`endif
  output logic                 busy,
  output logic                 DONE,
  output logic [2*WIDTH-1:0]   result
);

  localparam int              CNT_W     = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             step;
  logic             negate;
  logic             commit;
  logic             busy_next;
  logic             op_sgn;

`ifdef SEQ_MULT_SIGNED_EN
  assign op_sgn = sgn;
`else
  assign op_sgn = 1'b0;
`endif

  // Next-state and datapath enables; FIN both commits the product and may accept a new op.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    negate     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (cnt == LAST_STEP) begin
`ifdef SEQ_MULT_SIGNED_EN
          state_next = FIX;
`else
          state_next = FIN;
`endif
        end
      end
`ifdef SEQ_MULT_SIGNED_EN
      FIX: begin
        // Taken for every op, signed or not, so latency does not depend on sgn.
        negate     = 1'b1;
        state_next = FIN;
      end
`endif
      FIN: begin
        commit = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = CALC;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    busy_next = (state_next == CALC) || (state_next == FIX);
  end

  // State register plus registered busy/DONE so no input reaches an output combinationally.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      busy  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= busy_next;
      // DONE rises together with the committed result, one edge after FIN is entered.
      DONE  <= commit;
    end
  end

  // Step counter: cleared on every accept, advanced once per shift-add step.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  seq_mult_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk    (clk),
    .rst    (RESET),
    .load   (load),
    .step   (step),
    .negate (negate),
    .commit (commit),
    .x      (x),
    .y      (y),
    .sgn    (op_sgn),
    .result (result)
  );

endmodule

// File: tb/tb_seq_multiplier.sv
`timescale 1ns/1ps
// tb_seq_multiplier: randomized and directed stimulus against a cycle-accurate timing/arithmetic model.
// Latency: model expects DONE LAT edges after each accepted start.
// Backpressure: model drops any start seen before the previous op's FIN sampling edge.
module tb_seq_multiplier;

  localparam int W = 8;
`ifdef SEQ_MULT_SIGNED_EN
  localparam int LAT          = W + 2;
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam int LAT          = W + 1;
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           RESET;
  logic           start;
  logic [W-1:0]   x;
  logic [W-1:0]   y;
`ifdef SEQ_MULT_SIGNED_EN
  logic           sgn;
`endif
  logic           busy;
  logic           DONE;
  logic [2*W-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: edge counter, last acceptance, pending completion.
  int             e         = 0;
  int             acc_edge  = -1000;
  int             done_edge = -1;
  int             next_ok   = 0;
  logic [2*W-1:0] pend      = '0;
  logic [2*W-1:0] res_model = '0;
  logic [2*W-1:0] seen[$];
  int             seen_e[$];
  logic [2*W-1:0] b2b_exp[3];
  logic [W-1:0]   b2b_x[3];
  logic [W-1:0]   b2b_y[3];

  seq_multiplier #(.WIDTH(W)) dut (
    .clk    (clk),
    .RESET  (RESET),
    .start  (start),
    .x      (x),
    .y      (y),
`ifdef SEQ_MULT_SIGNED_EN
    .sgn    (sgn),
`endif
    .busy   (busy),
    .DONE   (DONE),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, e);
    end
  endtask

  // Reference product from plain integer arithmetic, truncated to 2*W bits.
  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
    longint sa;
    longint sb;
    longint p;
    sa = longint'(a);
    sb = longint'(b);
    if (SIGNED_BUILD && s) begin
      if (a[W-1]) sa = sa - (longint'(1) << W);
      if (b[W-1]) sb = sb - (longint'(1) << W);
    end
    p = sa * sb;
    return p[2*W-1:0];
  endfunction

  function automatic logic [W-1:0] rnd();
    return W'($urandom);
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom);
    endcase
  endfunction

  // One clock: drive inputs, advance the model at the edge, compare outputs at the negedge.
  task automatic step(input logic st, input logic [W-1:0] xv, input logic [W-1:0] yv,
                      input logic sv);
    logic exp_done;
    logic exp_busy;
    start = st;
    x     = xv;
    y     = yv;
`ifdef SEQ_MULT_SIGNED_EN
    sgn   = sv;
`endif
    @(posedge clk);
    e++;
    exp_done = (e == done_edge);
    if (exp_done) res_model = pend;
    if (st && e >= next_ok) begin
      acc_edge  = e;
      done_edge = e + LAT;
      next_ok   = e + LAT;
      pend      = ref_prod(xv, yv, sv);
    end
    exp_busy = (e >= acc_edge) && (e <= acc_edge + LAT - 2);
    @(negedge clk);
    check("done", 64'(DONE), 64'(exp_done));
    check("busy", 64'(busy), 64'(exp_busy));
    check("result", 64'(result), 64'(res_model));
    if (DONE) begin
      seen.push_back(result);
      seen_e.push_back(e);
    end
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear without any edge.
  task automatic abort_reset();
    #2 RESET = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(DONE), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    #1 RESET = 1'b0;
    res_model = '0;
    pend      = '0;
    done_edge = -1;
    acc_edge  = -1000;
    next_ok   = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    start = 1'b0;
    x     = '0;
    y     = '0;
`ifdef SEQ_MULT_SIGNED_EN
    sgn   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(DONE), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    RESET = 1'b0;

    // Basic products, operands scrambled while busy.
    step(1'b1, 8'd13, 8'd11, 1'b0);
    repeat (LAT + 2) step(1'b0, rnd(), rnd(), 1'b0);
    check("p13x11", 64'(result), 64'd143);
    step(1'b1, 8'd255, 8'd255, 1'b0);
    repeat (LAT + 2) step(1'b0, rnd(), rnd(), 1'b0);
    check("p255x255", 64'(result), 64'hFE01);
    step(1'b1, 8'd0, 8'd200, 1'b0);
    repeat (LAT + 2) step(1'b0, rnd(), rnd(), 1'b0);
    check("p0x200", 64'(result), 64'd0);

    // Back-to-back with start held high.
    b2b_x[0] = 8'd2; b2b_y[0] = 8'd3; b2b_exp[0] = 16'd6;
    b2b_x[1] = 8'd4; b2b_y[1] = 8'd5; b2b_exp[1] = 16'd20;
    b2b_x[2] = 8'd6; b2b_y[2] = 8'd7; b2b_exp[2] = 16'd42;
    seen.delete();
    seen_e.delete();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, b2b_x[i], b2b_y[i], 1'b0);
      repeat (LAT - 1) step(1'b1, rnd(), rnd(), 1'b0);
    end
    repeat (3) step(1'b0, rnd(), rnd(), 1'b0);
    check("b2b_count", 64'(seen.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      check("b2b_value", 64'((i < seen.size()) ? seen[i] : 16'hDEAD), 64'(b2b_exp[i]));
    end
    for (int i = 1; i < 3; i++) begin
      check("b2b_period", 64'((i < seen_e.size()) ? (seen_e[i] - seen_e[i-1]) : 0), 64'(LAT));
    end

    // Start pulse mid-CALC is dropped.
    seen.delete();
    step(1'b1, 8'd9, 8'd9, 1'b0);
    step(1'b0, rnd(), rnd(), 1'b0);
    step(1'b0, rnd(), rnd(), 1'b0);
    step(1'b1, 8'd1, 8'd1, 1'b0);
    repeat (LAT + 2) step(1'b0, rnd(), rnd(), 1'b0);
    check("drop_count", 64'(seen.size()), 64'd1);
    check("p9x9", 64'(result), 64'd81);

    // Reset in the middle of 200x100, then a fresh op.
    step(1'b1, 8'd200, 8'd100, 1'b0);
    repeat (3) step(1'b0, rnd(), rnd(), 1'b0);
    abort_reset();
    repeat (LAT + 2) step(1'b0, rnd(), rnd(), 1'b0);
    step(1'b1, 8'd7, 8'd7, 1'b0);
    repeat (LAT + 1) step(1'b0, rnd(), rnd(), 1'b0);
    check("p7x7", 64'(result), 64'd49);

`ifdef SEQ_MULT_SIGNED_EN
    step(1'b1, 8'hFD, 8'd5, 1'b1);
    repeat (LAT + 1) step(1'b0, rnd(), rnd(), 1'b0);
    check("s_m3x5", 64'(result), 64'hFFF1);
    step(1'b1, 8'h80, 8'h80, 1'b1);
    repeat (LAT + 1) step(1'b0, rnd(), rnd(), 1'b0);
    check("s_m128xm128", 64'(result), 64'd16384);
    step(1'b1, 8'h80, 8'h00, 1'b1);
    repeat (LAT + 1) step(1'b0, rnd(), rnd(), 1'b0);
    check("s_m128x0", 64'(result), 64'd0);
`endif

    // Randomized traffic: random start density, corner-heavy operands, random sign mode.
    repeat (400) begin
      step($urandom_range(0, 2) == 0, pick(), pick(), 1'($urandom_range(0, 1)));
    end
    repeat (LAT + 2) step(1'b0, rnd(), rnd(), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
